// File: rtl/hc_write_scheduler.sv
// ============================================================================
// hc_write_scheduler: round-robin arbiter that shares one buffer write channel
// between N_CLIENTS requesters and issues a single write-finish when all are done.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hc_write_scheduler #(
  parameter int N_CLIENTS = 4,
  parameter int ID_W      = 8,
  parameter int OFF_W     = 32,
  parameter int DATA_W    = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [N_CLIENTS-1:0]        cl_valid_i,
  input  logic [N_CLIENTS-1:0]        cl_indexed_i,
  input  logic [N_CLIENTS*ID_W-1:0]   cl_id_i,
  input  logic [N_CLIENTS*OFF_W-1:0]  cl_offset_i,
  input  logic [N_CLIENTS*DATA_W-1:0] cl_data_i,
  output logic [N_CLIENTS-1:0]        cl_ready_o,
  input  logic [N_CLIENTS-1:0]        cl_done_i,
  output logic [1:0]                  wr_cmd_o,
  output logic [ID_W-1:0]             wr_id_o,
  output logic [OFF_W-1:0]            wr_offset_o,
  output logic [DATA_W-1:0]           wr_data_o,
  output logic                        wr_valid_o,
  input  logic                        wr_full_i,
  output logic                        busy_o,
  output logic                        finished_o,
  output logic [31:0]                 beat_count_o
);

  localparam int PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_STREAM  = 2'd1;
  localparam logic [1:0] CMD_INDEXED = 2'd2;
  localparam logic [1:0] CMD_FINISH  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [N_CLIENTS-1:0] done_q;
  logic [1:0]           wr_cmd_q;
  logic [ID_W-1:0]      wr_id_q;
  logic [OFF_W-1:0]     wr_offset_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic                 wr_valid_q;
  logic                 busy_q;
  logic                 finished_q;
  logic [31:0]          beat_count_q;

  logic [N_CLIENTS-1:0] grant_d;
  logic [PTR_W-1:0]     gidx_d;
  logic                 found_d;
  logic                 transfer_d;
  logic                 all_done_d;
  logic [PTR_W-1:0]     ptr_next_d;
  logic [ID_W-1:0]      sel_id_d;
  logic [OFF_W-1:0]     sel_offset_d;
  logic [DATA_W-1:0]    sel_data_d;
  logic                 sel_indexed_d;

  // First valid client at or after the pointer, wrapping modulo N_CLIENTS.
  always_comb begin
    int               sum;
    logic [PTR_W-1:0] idx;
    grant_d = '0;
    gidx_d  = '0;
    found_d = 1'b0;
    sum     = 0;
    idx     = '0;
    if (state_q == S_RUN && !wr_full_i) begin
      for (int k = 0; k < N_CLIENTS; k++) begin
        sum = int'(ptr_q) + k;
        if (sum >= N_CLIENTS) sum = sum - N_CLIENTS;
        idx = PTR_W'(sum);
        if (!found_d && cl_valid_i[idx]) begin
          grant_d[idx] = 1'b1;
          gidx_d       = idx;
          found_d      = 1'b1;
        end
      end
    end
  end

  assign transfer_d    = found_d;
  assign ptr_next_d    = (int'(gidx_d) == N_CLIENTS - 1) ? '0 : gidx_d + PTR_W'(1);
  assign sel_id_d      = cl_id_i[gidx_d*ID_W +: ID_W];
  assign sel_offset_d  = cl_offset_i[gidx_d*OFF_W +: OFF_W];
  assign sel_data_d    = cl_data_i[gidx_d*DATA_W +: DATA_W];
  assign sel_indexed_d = cl_indexed_i[gidx_d];
  assign all_done_d    = (&(done_q | cl_done_i)) && (cl_valid_i == '0) && !transfer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      done_q       <= '0;
      wr_cmd_q     <= CMD_IDLE;
      wr_id_q      <= '0;
      wr_offset_q  <= '0;
      wr_data_q    <= '0;
      wr_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      beat_count_q <= '0;
    end else begin
      // Every beat is a single-cycle pulse; data alone holds between beats.
      wr_cmd_q    <= CMD_IDLE;
      wr_id_q     <= '0;
      wr_offset_q <= '0;
      wr_valid_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q      <= S_RUN;
            ptr_q        <= '0;
            done_q       <= '0;
            beat_count_q <= '0;
            busy_q       <= 1'b1;
            finished_q   <= 1'b0;
          end
        end
        S_RUN: begin
          done_q <= done_q | cl_done_i;
          if (transfer_d) begin
            wr_valid_q   <= 1'b1;
            wr_cmd_q     <= sel_indexed_d ? CMD_INDEXED : CMD_STREAM;
            wr_id_q      <= sel_id_d;
            wr_offset_q  <= sel_indexed_d ? sel_offset_d : '0;
            wr_data_q    <= sel_data_d;
            ptr_q        <= ptr_next_d;
            beat_count_q <= beat_count_q + 32'd1;
          end else if (all_done_d) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q <= done_q | cl_done_i;
          if (!wr_full_i) begin
            wr_valid_q <= 1'b1;
            wr_cmd_q   <= CMD_FINISH;
            wr_data_q  <= DATA_W'(1);
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cl_ready_o   = grant_d;
  assign wr_cmd_o     = wr_cmd_q;
  assign wr_id_o      = wr_id_q;
  assign wr_offset_o  = wr_offset_q;
  assign wr_data_o    = wr_data_q;
  assign wr_valid_o   = wr_valid_q;
  assign busy_o       = busy_q;
  assign finished_o   = finished_q;
  assign beat_count_o = beat_count_q;

endmodule

`default_nettype wire
